// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing for the sequential restoring divider
package div_pkg;

    localparam int DIV_W = 8;

    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (swap point for approximate subtractors)
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] div_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] diff;

    // Extra top bit is the borrow: set when the trial subtraction went negative.
    assign diff  = {1'b0, rem_i} - {2'b00, div_i};
    assign q_o   = ~diff[W+1];
    assign rem_o = q_o ? diff[W:0] : rem_i;

endmodule

// File: rtl/seq_div_2w_w.sv
// rtl/seq_div_2w_w.sv - 2W/W unsigned restoring divider, one quotient bit per cycle, valid/ready I/O
module seq_div_2w_w
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2*W-1:0] IN1,
    input  logic [W-1:0]   IN2,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   Quot,
    output logic [W-1:0]   Rem,
    output logic           ovf,
    output logic           dz,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int CW = div_cnt_w(W);

    div_state_e     state_q, state_d;
    logic [2*W:0]   sr_q, sr_d;
    logic [W-1:0]   div_q, div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    logic [W:0]     step_rem;
    logic           step_q;

    // Upper W+1 bits of the shift register after the left shift feed the step.
    div_step #(.W(W)) u_step (
        .rem_i (sr_q[2*W-1:W-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d  = {1'b0, IN1};
                    div_d = IN2;
                    cnt_d = '0;
                    if (IN2 == '0) begin
                        quot_d  = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (IN1[2*W-1:W] >= IN2) begin
                        // Quotient would need more than W bits.
                        quot_d  = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                sr_d  = {step_rem, sr_q[W-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    quot_d  = {sr_q[W-2:0], step_q};
                    rem_d   = step_rem[W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Quot      = quot_q;
    assign Rem       = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
